// File: rtl/dac_pkg.sv
// Shared definitions for the DAC command queue: opcodes, FSM states,
// queue entry layout and parameter defaults.
package dac_pkg;

    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 32;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_RESET = 4'b0001;
    localparam logic [3:0] OP_SET   = 4'b0010;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]  channel;
        logic [11:0] code;
    } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. The head entry is visible on
// rdata without a read latency, so a pop can capture it in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when a pop frees a slot
    // in the same cycle; a pop never happens on an empty FIFO.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage write; flush discards whatever is written alongside it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dac_cmd_queue.sv
// Queues DAC set commands and issues them one at a time, handshaking on a
// ready line that must dip low and return high for each command.
//
// state        | meaning
// ST_INIT      | issue one reset command (held off for one cycle after rst)
// ST_IDLE      | service pending init, or pop next entry when DAC is ready
// ST_ISSUE     | strobe the popped set command for one cycle
// ST_WAIT_LOW  | wait for the DAC to drop ready (bounded by TIMEOUT)
// ST_WAIT_HIGH | wait for the DAC to raise ready again (bounded by TIMEOUT)
module dac_cmd_queue
    import dac_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [1:0]               wr_channel,
    input  logic [11:0]              wr_code,
    input  logic                     init,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     err_timeout,
    output logic                     dac_cs,
    output logic [3:0]               dac_op,
    output logic [7:0]               dac_addr,
    output logic [15:0]              dac_data,
    input  logic                     dac_rdy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        next_state;
    logic          armed;
    logic          init_latch;
    logic          init_pend;
    logic          pop;
    logic          flush;
    logic          tmo;
    logic [TW-1:0] tmr;
    cmd_t          head;
    cmd_t          cmd_q;
    cmd_t          wr_cmd;

    assign wr_cmd    = '{channel: wr_channel, code: wr_code};
    assign init_pend = init || init_latch;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wr_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Next-state decode, pop/flush requests and timeout detection.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        flush      = 1'b0;
        tmo        = 1'b0;
        case (state)
            ST_INIT: begin
                if (armed) next_state = ST_WAIT_LOW;
            end
            ST_IDLE: begin
                if (init_pend) begin
                    flush      = 1'b1;
                    next_state = ST_INIT;
                end else if (!empty && dac_rdy) begin
                    pop        = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                if (!dac_rdy) begin
                    next_state = ST_WAIT_HIGH;
                end else if (tmr == '0) begin
                    tmo        = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (dac_rdy) begin
                    next_state = ST_IDLE;
                end else if (tmr == '0) begin
                    tmo        = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    // State register; armed keeps the reset strobe out of the reset period
    // so INIT's strobe always lands in the first cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    // Per-state down-counter, reloaded on every state change; terminal
    // count zero means TIMEOUT cycles have been spent in the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= TW'(TIMEOUT - 1);
        end else if (next_state != state) begin
            tmr <= TW'(TIMEOUT - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
        end
    end

    // Init latch and sticky flags; servicing an init clears them all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_latch  <= 1'b0;
            overflow    <= 1'b0;
            err_timeout <= 1'b0;
        end else if (flush) begin
            init_latch  <= 1'b0;
            overflow    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (init) init_latch <= 1'b1;
            if (wr_en && full && !pop) overflow <= 1'b1;
            if (tmo) err_timeout <= 1'b1;
        end
    end

    // Capture the popped entry so address/data stay stable while issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q <= '0;
        end else if (pop) begin
            cmd_q <= head;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign dac_cs   = ((state == ST_INIT) && armed) || (state == ST_ISSUE);
    assign dac_op   = (state == ST_ISSUE) ? OP_SET : (dac_cs ? OP_RESET : OP_NONE);
    assign dac_addr = {6'b0, cmd_q.channel};
    assign dac_data = {4'b0, cmd_q.code};

endmodule

// File: tb/tb_dac_cmd_queue.sv
// Bench for dac_cmd_queue: a DAC ready model and a command log are advanced
// once per cycle from a single thread; logged commands are compared with an
// expected list built from the pushes each scenario performs.
module tb_dac_cmd_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;
    localparam int M_AUTO    = 0;
    localparam int M_MANUAL  = 1;
    localparam int M_NOLOWER = 2;
    localparam logic [27:0] RESET_CMD = {4'b0001, 24'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_channel = '0;
    logic [11:0] wr_code = '0;
    logic        init = 1'b0;
    logic        dac_rdy = 1'b1;
    logic        full, empty, busy, overflow, err_timeout, dac_cs;
    logic [3:0]  count;
    logic [3:0]  dac_op;
    logic [7:0]  dac_addr;
    logic [15:0] dac_data;

    int checks = 0;
    int errors = 0;
    int mode = M_AUTO;
    int low_len = 3;
    int low_cnt = 0;
    logic [27:0] obs [$];
    logic [27:0] exp_q [$];

    always #5 clk = ~clk;

    dac_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_channel  (wr_channel),
        .wr_code     (wr_code),
        .init        (init),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .err_timeout (err_timeout),
        .dac_cs      (dac_cs),
        .dac_op      (dac_op),
        .dac_addr    (dac_addr),
        .dac_data    (dac_data),
        .dac_rdy     (dac_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] set_cmd(input logic [1:0] ch, input logic [11:0] code);
        return {4'b0010, 6'b0, ch, 4'b0, code};
    endfunction

    // Advance one cycle: log any strobe, then update the DAC ready model.
    task automatic step();
        @(negedge clk);
        if (dac_cs) obs.push_back({dac_op, dac_addr, dac_data});
        case (mode)
            M_AUTO: begin
                if (dac_cs) begin
                    low_cnt = low_len;
                    dac_rdy = 1'b0;
                end else if (low_cnt > 0) begin
                    low_cnt--;
                    if (low_cnt == 0) dac_rdy = 1'b1;
                end
            end
            M_NOLOWER: dac_rdy = 1'b1;
            default: ;
        endcase
    endtask

    task automatic push(input logic [1:0] ch, input logic [11:0] code);
        wr_en      = 1'b1;
        wr_channel = ch;
        wr_code    = code;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while ((busy || !empty) && n < bound) begin
            step();
            n++;
        end
        check({tag, "_settle"}, 32'(busy || !empty), 32'd0);
    endtask

    task automatic compare_obs(input string tag);
        check({tag, "_ncmd"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            if (exp_q[i] == RESET_CMD)
                check({tag, "_rstop"}, 32'(obs[i][27:24]), 32'd1);
            else
                check({tag, "_cmd"}, 32'(obs[i]), 32'(exp_q[i]));
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0]  ch;
        logic [11:0] code;

        // Reset values
        repeat (3) step();
        check("rst_cs",    32'(dac_cs),      32'd0);
        check("rst_op",    32'(dac_op),      32'd0);
        check("rst_addr",  32'(dac_addr),    32'd0);
        check("rst_data",  32'(dac_data),    32'd0);
        check("rst_count", 32'(count),       32'd0);
        check("rst_empty", 32'(empty),       32'd1);
        check("rst_full",  32'(full),        32'd0);
        check("rst_ovf",   32'(overflow),    32'd0);
        check("rst_tmo",   32'(err_timeout), 32'd0);

        // Power-up reset command
        rst = 1'b0;
        wait_idle("pwrup", 100);
        exp_q.push_back(RESET_CMD);
        compare_obs("pwrup");
        check("pwrup_busy", 32'(busy), 32'd0);

        // Single set command with latency check
        push(2'd2, 12'hABC);
        check("lat_early", 32'(dac_cs), 32'd0);
        step();
        check("lat_cs",   32'(dac_cs),   32'd1);
        check("lat_op",   32'(dac_op),   32'h2);
        check("lat_addr", 32'(dac_addr), 32'h02);
        check("lat_data", 32'(dac_data), 32'h0ABC);
        step();
        check("lat_one_cycle", 32'(dac_cs), 32'd0);
        check("lat_op_idle",   32'(dac_op), 32'd0);
        wait_idle("single", 100);
        exp_q.push_back(set_cmd(2'd2, 12'hABC));
        compare_obs("single");

        // Random traffic, pushing only when not full
        for (int i = 0; i < 20; i++) begin
            int g = 0;
            repeat ($urandom_range(0, 3)) step();
            while (full && g < 200) begin
                step();
                g++;
            end
            ch   = 2'($urandom);
            code = 12'($urandom);
            push(ch, code);
            exp_q.push_back(set_cmd(ch, code));
        end
        wait_idle("rand", 2000);
        compare_obs("rand");
        check("rand_ovf", 32'(overflow), 32'd0);

        // Overflow with a stalled DAC
        mode = M_MANUAL;
        dac_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ch   = 2'($urandom);
            code = 12'($urandom);
            push(ch, code);
            if (i < DEPTH) exp_q.push_back(set_cmd(ch, code));
        end
        check("ovf_full",  32'(full),     32'd1);
        check("ovf_count", 32'(count),    32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        mode = M_AUTO;
        low_cnt = 0;
        dac_rdy = 1'b1;
        wait_idle("ovf", 500);
        compare_obs("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // DAC never lowers ready -> timeout, then recovery
        mode = M_NOLOWER;
        push(2'd1, 12'h123);
        exp_q.push_back(set_cmd(2'd1, 12'h123));
        begin
            int n = 0;
            while (!dac_cs && n < 10) begin
                step();
                n++;
            end
        end
        check("tmo_cs_seen", 32'(dac_cs), 32'd1);
        repeat (TIMEOUT) step();
        check("tmo_early", 32'(err_timeout), 32'd0);
        repeat (2) step();
        check("tmo_flag", 32'(err_timeout), 32'd1);
        check("tmo_idle", 32'(busy),        32'd0);
        mode = M_AUTO;
        low_cnt = 0;
        push(2'd3, 12'hFED);
        exp_q.push_back(set_cmd(2'd3, 12'hFED));
        wait_idle("tmo", 200);
        compare_obs("tmo");

        // init during WAIT_HIGH with entries queued
        low_len = 10;
        push(2'd0, 12'h111);
        exp_q.push_back(set_cmd(2'd0, 12'h111));
        push(2'd1, 12'h222);
        push(2'd2, 12'h333);
        push(2'd3, 12'h444);
        repeat (2) step();
        check("init_busy",    32'(busy),        32'd1);
        check("init_rdy_low", 32'(dac_rdy),     32'd0);
        check("init_queued",  32'(count),       32'd3);
        check("init_pre_ovf", 32'(overflow),    32'd1);
        check("init_pre_tmo", 32'(err_timeout), 32'd1);
        init = 1'b1;
        step();
        init = 1'b0;
        push(2'd1, 12'h555);
        wait_idle("init", 300);
        exp_q.push_back(RESET_CMD);
        compare_obs("init");
        check("init_count", 32'(count),       32'd0);
        check("init_ovf",   32'(overflow),    32'd0);
        check("init_tmo",   32'(err_timeout), 32'd0);
        low_len = 3;

        // Simultaneous push and pop at full, across pointer wrap
        mode = M_MANUAL;
        dac_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ch   = 2'($urandom);
            code = 12'($urandom);
            push(ch, code);
            exp_q.push_back(set_cmd(ch, code));
        end
        check("pp_full_pre", 32'(full), 32'd1);
        ch   = 2'($urandom);
        code = 12'($urandom);
        exp_q.push_back(set_cmd(ch, code));
        mode = M_AUTO;
        low_cnt = 0;
        dac_rdy = 1'b1;
        push(ch, code);
        check("pp_count", 32'(count),    32'd8);
        check("pp_ovf",   32'(overflow), 32'd0);
        check("pp_cs",    32'(dac_cs),   32'd1);
        wait_idle("pp", 500);
        compare_obs("pp");

        // Reset in the middle of a command
        push(2'd0, 12'h5A5);
        exp_q.push_back(set_cmd(2'd0, 12'h5A5));
        push(2'd1, 12'h0F0);
        step();
        rst = 1'b1;
        step();
        check("mid_rst_cs",    32'(dac_cs), 32'd0);
        check("mid_rst_count", 32'(count),  32'd0);
        check("mid_rst_busy",  32'(busy),   32'd1);
        rst = 1'b0;
        wait_idle("mid_rst", 200);
        exp_q.push_back(RESET_CMD);
        compare_obs("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_cmd_queue.md
DAC_CMD_QUEUE -- requirements
Module: dac_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of 2).
REQ-002 Parameter TIMEOUT, default 32, max cycles waited per rdy edge.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  push {wr_channel, wr_code} this cycle.
REQ-006 wr_channel  input  2  target DAC channel A..D.
REQ-007 wr_code  input  12  DAC code.
REQ-008 init  input  1  one-cycle request: flush queue, reset DAC, clear flags.
REQ-009 full, empty  output  1 each  FIFO status.
REQ-010 count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 overflow, err_timeout  output  1 each  sticky error flags.
REQ-013 dac_cs  output  1  one-cycle command strobe to the DAC interface.
REQ-014 dac_op  output  4  0001 = reset, 0010 = set, else 0000.
REQ-015 dac_addr  output  8  {6'b0, channel}.
REQ-016 dac_data  output  16  {4'b0, code}.
REQ-017 dac_rdy  input  1  DAC interface ready.

Function
REQ-018 States SHALL be INIT, IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-019 INIT SHALL drive dac_cs=1 and dac_op=0001 for exactly one cycle, then go to WAIT_LOW.
REQ-020 IDLE with init pending SHALL flush the FIFO, clear overflow and err_timeout, and go to INIT.
REQ-021 IDLE with no init pending, !empty and dac_rdy=1 SHALL pop the head entry and go to ISSUE.
REQ-022 ISSUE SHALL drive dac_cs=1, dac_op=0010, addr and data from the popped entry for exactly one cycle, then go to WAIT_LOW.
REQ-023 WAIT_LOW SHALL wait for dac_rdy=0, then go to WAIT_HIGH.
REQ-024 WAIT_HIGH SHALL wait for dac_rdy=1, then go to IDLE.
REQ-025 A per-state cycle counter SHALL reset on every state entry.
REQ-026 If the counter reaches TIMEOUT in WAIT_LOW or WAIT_HIGH: set err_timeout, go to IDLE.
REQ-027 dac_cs SHALL be 0 in every cycle not covered by REQ-019 and REQ-022; dac_op SHALL be 0000 when dac_cs=0.
REQ-028 Latency: from wr_en into an empty FIFO with dac_rdy=1 and state IDLE, dac_cs SHALL assert 2 cycles later.
REQ-029 An init pulse arriving outside IDLE SHALL be latched and serviced on the next IDLE cycle.
REQ-030 An entry written during an outstanding init SHALL be flushed.
REQ-031 wr_en while full with no pop in the same cycle SHALL drop the data and set overflow.
REQ-032 wr_en with a pop in the same cycle while full SHALL accept the write; count stays unchanged.
REQ-033 wr_en while empty SHALL never pop in the same cycle.
REQ-034 FIFO pointers SHALL wrap modulo DEPTH.
REQ-035 count SHALL never exceed DEPTH.

Reset
REQ-036 On rst: state INIT, FIFO empty, count=0, all flags 0, dac_cs=0, dac_op=0, dac_addr=0, dac_data=0, init latch cleared.
REQ-037 Reset mid-operation SHALL abort immediately; after release the INIT sequence re-runs.

Structure
REQ-038 Shared package dac_pkg SHALL hold OP_RESET, OP_SET, the state encodings, and the DEPTH and TIMEOUT defaults.
REQ-039 The FIFO SHALL be a sub-module sync_fifo (push, pop, full, empty, count); the FSM stays in dac_cmd_queue.

Verification
REQ-040 Reset release with a DAC model (rdy low 3 cycles after cs) -> one cs with op=0001; busy falls once rdy returns high.
REQ-041 Push (ch=2, code=0xABC) -> exactly one cs pulse with op=0010, addr=0x02, data=0x0ABC.
REQ-042 Push 9 entries with DEPTH=8 and DAC stalled -> full=1, overflow=1, first 8 entries issued in order.
REQ-043 DAC model never lowers rdy -> err_timeout=1 after 32 cycles; queue resumes on the next entry.
REQ-044 init pulse during WAIT_HIGH with 3 entries queued -> current write completes, FIFO flushed, op=0001 issued, flags cleared.
REQ-045 Simultaneous push and pop at full -> count stays 8, no overflow, order preserved across pointer wrap.
